// File: rtl/game_scene_ctrl_pkg.sv
// game_scene_ctrl_pkg: VGA bus layout, scene codes, FSM states and default frame constants
package game_scene_ctrl_pkg;
   // VGA timing bus {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk}
   localparam int VGA_BUS_SIZE = 26;
   localparam int VBLNK_IDX = 13;
   localparam logic [1:0] SCENE_TITLE = 2'd0;
   localparam logic [1:0] SCENE_BOARD = 2'd1;
   localparam logic [1:0] SCENE_WIN = 2'd2;
   localparam int DEF_TITLE_FRAMES = 180;
   localparam int DEF_REVEAL_FRAMES = 60;
   localparam int DEF_PAIRS = 8;
   localparam int DEF_FCNT_W = 8;
   typedef enum logic [1:0] {S_TITLE, S_PLAY, S_REVEAL, S_WIN} state_t;
   function automatic logic [1:0] scene_of(input state_t s);
      return (s == S_WIN) ? SCENE_WIN : ((s == S_TITLE) ? SCENE_TITLE : SCENE_BOARD);
   endfunction
endpackage

// File: rtl/game_scene_ctrl_frame_tick_gen.sv
// frame_tick_gen: vblnk rising-edge detect with a combinational tick and a registered frame_tick
module frame_tick_gen (
   input  logic pclk,
   input  logic rst_n,
   input  logic vblnk,
   output logic tick,
   output logic frame_tick
);
   logic vblnk_d;
   assign tick = vblnk & ~vblnk_d;
   // remember last vblnk and delay tick by one cycle for downstream users
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         vblnk_d <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vblnk_d <= vblnk;
         frame_tick <= tick;
      end
   end
endmodule

// File: rtl/game_scene_ctrl.sv
// game_scene_ctrl: frame-synchronous scene sequencer for the Memory Game
module game_scene_ctrl
   import game_scene_ctrl_pkg::*;
#(
   parameter int TITLE_FRAMES = DEF_TITLE_FRAMES,
   parameter int REVEAL_FRAMES = DEF_REVEAL_FRAMES,
   parameter int PAIRS = DEF_PAIRS,
   parameter int FCNT_W = DEF_FCNT_W
) (
   input  logic                    pclk,
   input  logic                    rst_n,
   input  logic [VGA_BUS_SIZE-1:0] vga_in,
   input  logic                    start_btn,
   input  logic                    pair_valid,
   input  logic                    pair_match,
   output logic [1:0]              scene,
   output logic                    title_en,
   output logic                    board_en,
   output logic                    win_en,
   output logic                    input_lock,
   output logic                    pair_commit,
   output logic                    pair_clear,
   output logic [3:0]              pairs_found,
   output logic                    frame_tick
);
   localparam logic [FCNT_W-1:0] TF = FCNT_W'(TITLE_FRAMES);
   localparam logic [FCNT_W-1:0] RF = FCNT_W'(REVEAL_FRAMES);
   localparam logic [FCNT_W-1:0] ONE = FCNT_W'(1);
   state_t state, state_nxt;
   logic [FCNT_W-1:0] fcnt, fcnt_nxt, rcnt, rcnt_nxt;
   logic start_pend, pend_nxt, start_d, start_rise, match_r, match_nxt;
   logic [3:0] pairs_nxt, pairs_inc;
   logic commit_nxt, clear_nxt, tick;
   logic unused_vga;
   assign unused_vga = ^{vga_in[VGA_BUS_SIZE-1:VBLNK_IDX+1], vga_in[VBLNK_IDX-1:0]};
   assign start_rise = start_btn & ~start_d;
   assign pairs_inc = pairs_found + 4'd1;
   assign input_lock = (state != S_PLAY);
   frame_tick_gen u_tick (
      .pclk(pclk),
      .rst_n(rst_n),
      .vblnk(vga_in[VBLNK_IDX]),
      .tick(tick),
      .frame_tick(frame_tick)
   );
   // state, counters and handshake pulses
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state <= S_TITLE;
         fcnt <= '0;
         rcnt <= '0;
         start_pend <= 1'b0;
         start_d <= 1'b0;
         match_r <= 1'b0;
         pairs_found <= 4'd0;
         pair_commit <= 1'b0;
         pair_clear <= 1'b0;
      end else begin
         state <= state_nxt;
         fcnt <= fcnt_nxt;
         rcnt <= rcnt_nxt;
         start_pend <= pend_nxt;
         start_d <= start_btn;
         match_r <= match_nxt;
         pairs_found <= pairs_nxt;
         pair_commit <= commit_nxt;
         pair_clear <= clear_nxt;
      end
   end
   // next-state logic; everything but pair acceptance waits for a frame tick
   always_comb begin
      state_nxt = state;
      fcnt_nxt = fcnt;
      rcnt_nxt = rcnt;
      pend_nxt = start_pend;
      match_nxt = match_r;
      pairs_nxt = pairs_found;
      commit_nxt = 1'b0;
      clear_nxt = 1'b0;
      case (state)
         S_TITLE: begin
            if (tick && start_pend) begin
               state_nxt = S_PLAY;
               fcnt_nxt = '0;
               pairs_nxt = 4'd0;
               pend_nxt = 1'b0;
            end else begin
               if (start_rise && fcnt == TF) pend_nxt = 1'b1;
               if (tick && fcnt != TF) fcnt_nxt = fcnt + ONE;
            end
         end
         S_PLAY: begin
            if (pair_valid) begin
               match_nxt = pair_match;
               rcnt_nxt = RF;
               state_nxt = S_REVEAL;
            end
         end
         S_REVEAL: begin
            if (tick) begin
               rcnt_nxt = rcnt - ONE;
               if (rcnt == ONE) begin
                  commit_nxt = match_r;
                  clear_nxt = ~match_r;
                  pairs_nxt = match_r ? pairs_inc : pairs_found;
                  state_nxt = (match_r && pairs_inc == 4'(PAIRS)) ? S_WIN : S_PLAY;
               end
            end
         end
         S_WIN: begin
            if (tick && start_pend) begin
               state_nxt = S_TITLE;
               fcnt_nxt = '0;
               pairs_nxt = 4'd0;
               pend_nxt = 1'b0;
            end else if (start_rise) begin
               pend_nxt = 1'b1;
            end
         end
         default: state_nxt = S_TITLE;
      endcase
   end
   // scene layer selection changes only at frame start to avoid tearing
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         scene <= SCENE_TITLE;
         title_en <= 1'b1;
         board_en <= 1'b0;
         win_en <= 1'b0;
      end else if (tick) begin
         scene <= scene_of(state_nxt);
         title_en <= (state_nxt == S_TITLE);
         board_en <= (state_nxt == S_PLAY) || (state_nxt == S_REVEAL);
         win_en <= (state_nxt == S_WIN);
      end
   end
endmodule

// File: tb/tb_game_scene_ctrl.sv
// tb_game_scene_ctrl: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_game_scene_ctrl;
   import game_scene_ctrl_pkg::*;
   logic pclk = 0, rst_n = 0, vblnk = 0, start_btn = 0, pair_valid = 0, pair_match = 0;
   logic [VGA_BUS_SIZE-1:0] vga_in = '0;
   logic [1:0] scene;
   logic title_en, board_en, win_en, input_lock, pair_commit, pair_clear, frame_tick;
   logic [3:0] pairs_found;
   int tests = 0, fails = 0, printed = 0;
   int phase = 0, frames = 0;
   bit chk_en = 0, done = 0;
   int n_commit = 0, n_clear = 0;
   game_scene_ctrl dut (
      .pclk(pclk), .rst_n(rst_n), .vga_in(vga_in), .start_btn(start_btn),
      .pair_valid(pair_valid), .pair_match(pair_match), .scene(scene),
      .title_en(title_en), .board_en(board_en), .win_en(win_en),
      .input_lock(input_lock), .pair_commit(pair_commit), .pair_clear(pair_clear),
      .pairs_found(pairs_found), .frame_tick(frame_tick)
   );
   always #5 pclk = ~pclk;
   // 20-cycle frames, vblnk high in the last 4; other bus bits carry noise
   always @(negedge pclk) begin
      logic [31:0] noise;
      phase = (phase == 19) ? 0 : phase + 1;
      vblnk = (phase >= 16);
      if (phase == 16) frames++;
      noise = $urandom;
      vga_in = noise[VGA_BUS_SIZE-1:0];
      vga_in[VBLNK_IDX] = vblnk;
   end
   // reference model: mode 0 title, 1 play, 2 reveal, 3 win
   int m_mode = 0, m_title_ticks = 0, m_left = 0, m_found = 0;
   bit m_pend = 0, m_match = 0, m_vb_p = 0, m_sb_p = 0, e_ft = 0, e_commit = 0, e_clear = 0;
   int e_scene = 0;
   always @(posedge pclk) begin
      bit tk, sr;
      int nm;
      if (!rst_n) begin
         m_mode = 0; m_title_ticks = 0; m_left = 0; m_found = 0; m_pend = 0; m_match = 0;
         m_vb_p = 0; m_sb_p = 0; e_scene = 0; e_ft = 0; e_commit = 0; e_clear = 0;
      end else begin
         tk = vblnk && !m_vb_p;
         sr = start_btn && !m_sb_p;
         nm = m_mode;
         e_ft = tk;
         e_commit = 0;
         e_clear = 0;
         if (m_mode == 0 || m_mode == 3) begin
            if (tk && m_pend) begin
               nm = (m_mode == 0) ? 1 : 0;
               m_title_ticks = 0; m_found = 0; m_pend = 0;
            end else begin
               if (sr && (m_mode == 3 || m_title_ticks >= 180)) m_pend = 1;
               if (tk && m_mode == 0) m_title_ticks++;
            end
         end else if (m_mode == 1) begin
            if (pair_valid) begin m_match = pair_match; m_left = 60; nm = 2; end
         end else if (tk) begin
            m_left--;
            if (m_left == 0) begin
               if (m_match) begin m_found++; e_commit = 1; nm = (m_found == 8) ? 3 : 1; end
               else begin e_clear = 1; nm = 1; end
            end
         end
         if (tk) e_scene = (nm == 0) ? 0 : (nm == 3) ? 2 : 1;
         m_mode = nm;
         m_vb_p = vblnk;
         m_sb_p = start_btn;
      end
   end
   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (printed < 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
         printed++;
      end
   endtask
   task automatic step();
      @(posedge pclk);
      #2;
   endtask
   task automatic wait_phase(input int p);
      int n = 0;
      step();
      while (phase != p && n < 40) begin step(); n++; end
      if (phase != p) chk("wait_phase_timeout", phase, p);
   endtask
   task automatic wait_frames_until(input int target);
      int n = 0;
      while (frames < target && n < 20000) begin step(); n++; end
      if (frames < target) chk("wait_frames_timeout", frames, target);
   endtask
   task automatic press_start();
      wait_phase(5);
      start_btn = 1;
      repeat (3) step();
      start_btn = 0;
   endtask
   task automatic do_pair(input bit m, input bit coincide, input bit inject);
      int fa, n;
      wait_phase(coincide ? 16 : 5);
      pair_valid = 1;
      pair_match = m;
      step();
      pair_valid = 0;
      pair_match = 0;
      fa = frames;
      chk("lock_after_pair", int'(input_lock), 1);
      if (inject) begin
         wait_frames_until(frames + 3);
         wait_phase(5);
         pair_valid = 1;
         pair_match = ~m;
         step();
         pair_valid = 0;
         pair_match = 0;
      end
      n = 0;
      while (!pair_commit && !pair_clear && n < 1400) begin step(); n++; end
      chk("reveal_ticks", frames - fa, 60);
      chk("commit_pulse", int'(pair_commit), int'(m));
      chk("clear_pulse", int'(pair_clear), int'(!m));
      if (pair_commit) n_commit++;
      if (pair_clear) n_clear++;
   endtask
   task automatic monitor();
      while (!done) begin
         @(negedge pclk);
         if (chk_en) begin
            chk("scene", int'(scene), e_scene);
            chk("title_en", int'(title_en), int'(e_scene == 0));
            chk("board_en", int'(board_en), int'(e_scene == 1));
            chk("win_en", int'(win_en), int'(e_scene == 2));
            chk("input_lock", int'(input_lock), int'(m_mode != 1));
            chk("pair_commit", int'(pair_commit), int'(e_commit));
            chk("pair_clear", int'(pair_clear), int'(e_clear));
            chk("pairs_found", int'(pairs_found), m_found);
            chk("frame_tick", int'(frame_tick), int'(e_ft));
         end
      end
   endtask
   task automatic stimulus();
      int f0, nft;
      step();
      chk_en = 1;
      repeat (3) step();
      wait_phase(19);
      rst_n = 1;
      f0 = frames;
      nft = 0;
      repeat (100) begin step(); if (frame_tick) nft++; end
      chk("ft_count_5_frames", nft, 5);
      chk("reset_scene", int'(scene), 0);
      chk("reset_title_en", int'(title_en), 1);
      chk("reset_lock", int'(input_lock), 1);
      chk("reset_pairs", int'(pairs_found), 0);
      wait_frames_until(f0 + 10);
      press_start();
      wait_frames_until(frames + 2);
      wait_phase(5);
      chk("early_start_ignored", int'(scene), 0);
      wait_frames_until(f0 + 181);
      press_start();
      wait_phase(15);
      chk("scene_before_tick", int'(scene), 0);
      wait_phase(16);
      chk("scene_play", int'(scene), 1);
      chk("board_en_play", int'(board_en), 1);
      chk("lock_play", int'(input_lock), 0);
      do_pair(0, 0, 0);
      chk("pairs_after_clear", int'(pairs_found), 0);
      step();
      chk("lock_after_clear", int'(input_lock), 0);
      for (int i = 1; i <= 8; i++) begin
         do_pair(1, i == 2, i == 3);
         chk("pairs_count", int'(pairs_found), i);
      end
      step();
      chk("scene_win", int'(scene), 2);
      chk("win_en", int'(win_en), 1);
      chk("lock_win", int'(input_lock), 1);
      wait_phase(5);
      pair_valid = 1;
      pair_match = 1;
      step();
      pair_valid = 0;
      pair_match = 0;
      press_start();
      wait_phase(15);
      chk("scene_still_win", int'(scene), 2);
      wait_phase(16);
      chk("scene_back_title", int'(scene), 0);
      chk("pairs_cleared", int'(pairs_found), 0);
      f0 = frames;
      wait_phase(5);
      pair_valid = 1;
      pair_match = 1;
      step();
      pair_valid = 0;
      pair_match = 0;
      wait_frames_until(frames + 2);
      chk("title_pair_ignored", int'(scene), 0);
      wait_frames_until(f0 + 181);
      press_start();
      wait_phase(16);
      chk("scene_play2", int'(scene), 1);
      wait_phase(5);
      pair_valid = 1;
      pair_match = 1;
      step();
      pair_valid = 0;
      pair_match = 0;
      wait_frames_until(frames + 30);
      wait_phase(5);
      rst_n = 0;
      step();
      chk("rst_scene", int'(scene), 0);
      chk("rst_title_en", int'(title_en), 1);
      chk("rst_board_en", int'(board_en), 0);
      chk("rst_win_en", int'(win_en), 0);
      chk("rst_lock", int'(input_lock), 1);
      chk("rst_commit", int'(pair_commit), 0);
      chk("rst_clear", int'(pair_clear), 0);
      chk("rst_ft", int'(frame_tick), 0);
      rst_n = 1;
      nft = 0;
      repeat (1300) begin step(); if (pair_commit || pair_clear) nft++; end
      chk("no_pulse_after_reset", nft, 0);
      chk("total_commits", n_commit, 8);
      chk("total_clears", n_clear, 1);
   endtask
   initial begin
      fork
         monitor();
         begin stimulus(); done = 1; end
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
